mc_ctrl: RTL and testbench

Multi-cycle MIPS control unit for the lab CPU. Sequences one instruction at a time through the shared datapath: PC, IR, register file, extender, ALU and unified memory. Generates every datapath control, including the extender's sign/zero select. Handshakes with memory through a ready signal, so fetch and data accesses may take any number of wait cycles.

---
 rtl/mc_ctrl_pkg.sv | 88 ++++++++
 rtl/mc_ctrl_if.sv | 45 ++++
 rtl/mc_ctrl_dec.sv | 87 ++++++++
 rtl/mc_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared constants for the multi-cycle MIPS control unit: state
//            encodings, opcode/funct values, datapath select codes and the
//            decoder result type.
// Revision : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

  // Controller state register encoding (visible on the debug port)
  typedef logic [2:0] state_t;
  localparam state_t c_ST_FETCH  = 3'd0;
  localparam state_t c_ST_DECODE = 3'd1;
  localparam state_t c_ST_EXE    = 3'd2;
  localparam state_t c_ST_MEM    = 3'd3;
  localparam state_t c_ST_WB     = 3'd4;
  localparam state_t c_ST_ILL    = 3'd7;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDIU = 6'h09;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] c_FN_ADDU = 6'h21;
  localparam logic [5:0] c_FN_SUBU = 6'h23;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_SLT  = 6'h2A;

  // ALU operation select
  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_SUB = 3'd1;
  localparam logic [2:0] c_ALU_AND = 3'd2;
  localparam logic [2:0] c_ALU_OR  = 3'd3;
  localparam logic [2:0] c_ALU_SLT = 3'd4;
  localparam logic [2:0] c_ALU_LUI = 3'd5;

  // Register-file write address select
  localparam logic [1:0] c_RDST_RT = 2'b00;
  localparam logic [1:0] c_RDST_RD = 2'b01;
  localparam logic [1:0] c_RDST_RA = 2'b10;

  // Register-file write data select
  localparam logic [1:0] c_M2R_ALUOUT = 2'b00;
  localparam logic [1:0] c_M2R_MDR    = 2'b01;
  localparam logic [1:0] c_M2R_PC     = 2'b10;

  // ALU B operand select
  localparam logic [1:0] c_SRCB_RT    = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
  localparam logic [1:0] c_SRCB_IMM   = 2'b10;
  localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_IALU  = 3'd1,
    CLS_LW    = 3'd2,
    CLS_SW    = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_J     = 3'd5,
    CLS_JAL   = 3'd6,
    CLS_ILL   = 3'd7
  } iclass_t;

  // Decoder result: class, execute-stage ALU op, extender mode, illegal flag
  typedef struct packed {
    iclass_t    cls;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       illegal;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_if
// Purpose  : Bundle between the control unit and the datapath/memory. The
//            master side is the controller; the slave side is the datapath.
// Revision : 1.0  initial release
// ============================================================================
interface mc_ctrl_if;

  // Datapath / memory status towards the controller
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  // Controls towards the datapath / memory
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_wr;
  logic       pc_wr;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       ext_op;
  logic [1:0] pc_src;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_rd, mem_wr, ir_wr, pc_wr, reg_wr, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, ext_op, pc_src, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_rd, mem_wr, ir_wr, pc_wr, reg_wr, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, ext_op, pc_src, illegal, state
  );

endinterface
`default_nettype wire

// File: rtl/mc_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_dec
// Purpose  : Combinational instruction decoder. Maps op/funct to an
//            instruction class, the execute-stage ALU op, the extender mode
//            and an illegal-instruction flag.
//            MC_CTRL_JAL_EN : when defined, jal (op 03) is a legal class;
//                             otherwise it decodes as illegal.
// Revision : 1.0  initial release
// ============================================================================
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  // Opcode/funct lookup; anything not matched falls through as illegal
  always_comb begin
    dec_o.cls     = CLS_ILL;
    dec_o.alu_op  = c_ALU_ADD;
    dec_o.ext_op  = 1'b1;
    dec_o.illegal = 1'b1;
    case (op_i)
      c_OP_RTYPE: begin
        case (funct_i)
          c_FN_ADDU: begin dec_o.cls = CLS_RTYPE; dec_o.alu_op = c_ALU_ADD; dec_o.illegal = 1'b0; end
          c_FN_SUBU: begin dec_o.cls = CLS_RTYPE; dec_o.alu_op = c_ALU_SUB; dec_o.illegal = 1'b0; end
          c_FN_AND:  begin dec_o.cls = CLS_RTYPE; dec_o.alu_op = c_ALU_AND; dec_o.illegal = 1'b0; end
          c_FN_OR:   begin dec_o.cls = CLS_RTYPE; dec_o.alu_op = c_ALU_OR;  dec_o.illegal = 1'b0; end
          c_FN_SLT:  begin dec_o.cls = CLS_RTYPE; dec_o.alu_op = c_ALU_SLT; dec_o.illegal = 1'b0; end
          default:   ;
        endcase
      end
      c_OP_ADDIU: begin
        dec_o.cls     = CLS_IALU;
        dec_o.alu_op  = c_ALU_ADD;
        dec_o.illegal = 1'b0;
      end
      c_OP_ORI: begin
        // Logical immediates are zero-extended
        dec_o.cls     = CLS_IALU;
        dec_o.alu_op  = c_ALU_OR;
        dec_o.ext_op  = 1'b0;
        dec_o.illegal = 1'b0;
      end
      c_OP_LUI: begin
        dec_o.cls     = CLS_IALU;
        dec_o.alu_op  = c_ALU_LUI;
        dec_o.illegal = 1'b0;
      end
      c_OP_LW: begin
        dec_o.cls     = CLS_LW;
        dec_o.alu_op  = c_ALU_ADD;
        dec_o.illegal = 1'b0;
      end
      c_OP_SW: begin
        dec_o.cls     = CLS_SW;
        dec_o.alu_op  = c_ALU_ADD;
        dec_o.illegal = 1'b0;
      end
      c_OP_BEQ: begin
        // Compare by subtraction; the ALU zero flag decides the branch
        dec_o.cls     = CLS_BEQ;
        dec_o.alu_op  = c_ALU_SUB;
        dec_o.illegal = 1'b0;
      end
      c_OP_J: begin
        dec_o.cls     = CLS_J;
        dec_o.illegal = 1'b0;
      end
      c_OP_JAL: begin
`ifdef MC_CTRL_JAL_EN
        dec_o.cls     = CLS_JAL;
        dec_o.illegal = 1'b0;
`else
        dec_o.cls     = CLS_ILL;
        dec_o.illegal = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle MIPS control unit. Sequences one instruction at a
//            time through FETCH/DECODE/EXE/MEM/WB over a shared datapath,
//            handshaking with memory via mem_ready. Undefined instructions
//            park the machine in ILL until reset.
//            MC_CTRL_JAL_EN : when defined, jal completes in DECODE
//                             (link to $31 and jump); otherwise it is illegal.
// Revision : 1.0  initial release
// ============================================================================
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_if.master     bus
);

  state_t state_q;
  state_t state_d;
  dec_t   w_dec;

  logic       w_mem_rd;
  logic       w_mem_wr;
  logic       w_ir_wr;
  logic       w_pc_wr;
  logic       w_reg_wr;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_op;
  logic       w_ext_op;
  logic [1:0] w_pc_src;
  logic       w_illegal;

  mc_ctrl_dec u_dec (
    .op_i    (bus.op),
    .funct_i (bus.funct),
    .dec_o   (w_dec)
  );

  // State register; reset parks the machine in FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; memory states hold until the handshake completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_FETCH: begin
        if (bus.mem_ready) state_d = c_ST_DECODE;
      end
      c_ST_DECODE: begin
        if (w_dec.illegal) begin
          state_d = c_ST_ILL;
        end else if (w_dec.cls == CLS_J || w_dec.cls == CLS_JAL) begin
          state_d = c_ST_FETCH;
        end else begin
          state_d = c_ST_EXE;
        end
      end
      c_ST_EXE: begin
        case (w_dec.cls)
          CLS_BEQ:        state_d = c_ST_FETCH;
          CLS_LW, CLS_SW: state_d = c_ST_MEM;
          default:        state_d = c_ST_WB;
        endcase
      end
      c_ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = (w_dec.cls == CLS_LW) ? c_ST_WB : c_ST_FETCH;
        end
      end
      c_ST_WB:  state_d = c_ST_FETCH;
      c_ST_ILL: state_d = c_ST_ILL;
      // Unused encodings recover to a clean fetch
      default:  state_d = c_ST_FETCH;
    endcase
  end

  // Datapath controls from the current state; all forced low during reset
  // so no request or write enable can coincide with it
  always_comb begin
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_ir_wr      = 1'b0;
    w_pc_wr      = 1'b0;
    w_reg_wr     = 1'b0;
    w_reg_dst    = c_RDST_RT;
    w_mem_to_reg = c_M2R_ALUOUT;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = c_SRCB_RT;
    w_alu_op     = c_ALU_ADD;
    w_ext_op     = 1'b0;
    w_pc_src     = c_PCSRC_ALU;
    w_illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        c_ST_FETCH: begin
          // PC + 4 is computed every cycle; IR/PC latch on the ready edge
          w_mem_rd    = 1'b1;
          w_alu_src_a = 1'b0;
          w_alu_src_b = c_SRCB_FOUR;
          w_alu_op    = c_ALU_ADD;
          w_pc_src    = c_PCSRC_ALU;
          w_ir_wr     = bus.mem_ready;
          w_pc_wr     = bus.mem_ready;
        end
        c_ST_DECODE: begin
          // Branch target PC + (sext imm << 2) is precomputed into ALUOut
          w_alu_src_a = 1'b0;
          w_alu_src_b = c_SRCB_IMMSH;
          w_ext_op    = 1'b1;
          w_alu_op    = c_ALU_ADD;
          if (w_dec.cls == CLS_J || w_dec.cls == CLS_JAL) begin
            w_pc_wr  = 1'b1;
            w_pc_src = c_PCSRC_JUMP;
          end
          if (w_dec.cls == CLS_JAL) begin
            // PC already holds the return address (PC + 4)
            w_reg_wr     = 1'b1;
            w_reg_dst    = c_RDST_RA;
            w_mem_to_reg = c_M2R_PC;
          end
        end
        c_ST_EXE: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = w_dec.alu_op;
          w_ext_op    = w_dec.ext_op;
          if (w_dec.cls == CLS_RTYPE || w_dec.cls == CLS_BEQ) begin
            w_alu_src_b = c_SRCB_RT;
          end else begin
            w_alu_src_b = c_SRCB_IMM;
          end
          if (w_dec.cls == CLS_BEQ) begin
            w_pc_src = c_PCSRC_ALUOUT;
            w_pc_wr  = bus.zero;
          end
        end
        c_ST_MEM: begin
          // Request stays constant until the memory reports ready
          w_mem_rd = (w_dec.cls == CLS_LW);
          w_mem_wr = (w_dec.cls == CLS_SW);
        end
        c_ST_WB: begin
          w_reg_wr     = 1'b1;
          w_ext_op     = w_dec.ext_op;
          w_reg_dst    = (w_dec.cls == CLS_RTYPE) ? c_RDST_RD : c_RDST_RT;
          w_mem_to_reg = (w_dec.cls == CLS_LW) ? c_M2R_MDR : c_M2R_ALUOUT;
        end
        c_ST_ILL: begin
          w_illegal = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_rd     = w_mem_rd;
  assign bus.mem_wr     = w_mem_wr;
  assign bus.ir_wr      = w_ir_wr;
  assign bus.pc_wr      = w_pc_wr;
  assign bus.reg_wr     = w_reg_wr;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.ext_op     = w_ext_op;
  assign bus.pc_src     = w_pc_src;
  assign bus.illegal    = w_illegal;
  assign bus.state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Self-checking bench for mc_ctrl. An instruction-level model
//            expands each instruction into its expected per-cycle control
//            trace, which is compared against the DUT every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       pc_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
    logic [1:0] pc_src;
    logic       illegal;
  } obs_t;

  typedef struct packed {
    logic rdy;
    obs_t o;
  } step_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_JAL = 6, K_ILL = 7;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  bit   g_tie = 1'b0;
  step_t exp_q[$];

  always #5 clk = ~clk;

  mc_ctrl_if bus_if ();

  mc_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Instruction grouping straight from the supported-instruction list
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A}) ? K_R : K_ILL;
      6'h09, 6'h0D, 6'h0F: return K_I;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
`ifdef MC_CTRL_JAL_EN
      6'h03: return K_JAL;
`endif
      default: return K_ILL;
    endcase
  endfunction

  // ALU operation expected in EXE
  function automatic logic [2:0] exe_alu(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h23:   return 3'd1;
        6'h24:   return 3'd2;
        6'h25:   return 3'd3;
        6'h2A:   return 3'd4;
        default: return 3'd0;
      endcase
    end
    case (op)
      6'h0D:   return 3'd3;
      6'h0F:   return 3'd5;
      6'h04:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic logic idle_rdy();
    return g_tie ? 1'b1 : 1'($urandom_range(1, 0));
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state      = bus_if.state;
    o.mem_rd     = bus_if.mem_rd;
    o.mem_wr     = bus_if.mem_wr;
    o.ir_wr      = bus_if.ir_wr;
    o.pc_wr      = bus_if.pc_wr;
    o.reg_wr     = bus_if.reg_wr;
    o.reg_dst    = bus_if.reg_dst;
    o.mem_to_reg = bus_if.mem_to_reg;
    o.alu_src_a  = bus_if.alu_src_a;
    o.alu_src_b  = bus_if.alu_src_b;
    o.alu_op     = bus_if.alu_op;
    o.ext_op     = bus_if.ext_op;
    o.pc_src     = bus_if.pc_src;
    o.illegal    = bus_if.illegal;
    return o;
  endfunction

  task automatic push(input logic r, input obs_t o);
    step_t s;
    s.rdy = r;
    s.o   = o;
    exp_q.push_back(s);
  endtask

  task automatic push_fetch_waits(input int n);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      o = blank(3'd0);
      o.mem_rd = 1'b1;
      o.alu_src_b = 2'b01;
      push(1'b0, o);
    end
  endtask

  // Expand one instruction into its expected cycle-by-cycle trace
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm, input int n_ill);
    int   k;
    logic ext;
    obs_t o;
    k   = kind_of(op, fn);
    ext = (op == 6'h0D) ? 1'b0 : 1'b1;
    push_fetch_waits(wf);
    o = blank(3'd0);
    o.mem_rd = 1'b1; o.alu_src_b = 2'b01; o.ir_wr = 1'b1; o.pc_wr = 1'b1;
    push(1'b1, o);
    o = blank(3'd1);
    o.alu_src_b = 2'b11; o.ext_op = 1'b1;
    if (k == K_J || k == K_JAL) begin o.pc_wr = 1'b1; o.pc_src = 2'b10; end
    if (k == K_JAL) begin o.reg_wr = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
    push(idle_rdy(), o);
    if (k == K_J || k == K_JAL) return;
    if (k == K_ILL) begin
      for (int i = 0; i < n_ill; i++) begin
        o = blank(3'd7);
        o.illegal = 1'b1;
        push(idle_rdy(), o);
      end
      return;
    end
    o = blank(3'd2);
    o.alu_src_a = 1'b1; o.ext_op = ext; o.alu_op = exe_alu(op, fn);
    o.alu_src_b = (k == K_R || k == K_BEQ) ? 2'b00 : 2'b10;
    if (k == K_BEQ) begin o.pc_src = 2'b01; o.pc_wr = z; end
    push(idle_rdy(), o);
    if (k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      o = blank(3'd3);
      o.mem_rd = (k == K_LW); o.mem_wr = (k == K_SW);
      for (int i = 0; i < wm; i++) push(1'b0, o);
      push(1'b1, o);
      if (k == K_SW) return;
    end
    o = blank(3'd4);
    o.reg_wr = 1'b1; o.ext_op = ext;
    o.reg_dst = (k == K_R) ? 2'b01 : 2'b00;
    o.mem_to_reg = (k == K_LW) ? 2'b01 : 2'b00;
    push(idle_rdy(), o);
  endtask

  // Replay the expected trace: drive at posedge+1, compare at negedge
  task automatic play(input string tag);
    step_t s;
    obs_t  got;
    int    cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      bus_if.mem_ready = s.rdy;
      @(negedge clk);
      got = sample();
      vectors++;
      assert (got === s.o) else begin
        miscompares++;
        $error("FAIL %s cyc%0d: got=%h (state %0d) exp=%h (state %0d)",
               tag, cyc, got, got.state, s.o, s.o.state);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_check(input int n, input string tag);
    obs_t got;
    obs_t zero_o;
    zero_o = '0;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus_if.mem_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      got = sample();
      vectors++;
      assert (got === zero_o) else begin
        miscompares++;
        $error("FAIL %s cyc%0d: got=%h exp=%h", tag, i, got, zero_o);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int wf, input int wm, input int n_ill, input string tag);
    bus_if.op    = op;
    bus_if.funct = fn;
    bus_if.zero  = z;
    model(op, fn, z, wf, wm, n_ill);
    play(tag);
    if (kind_of(op, fn) == K_ILL) reset_check(1, {tag, "_rst"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fn_tab [5];
    logic [5:0] op_tab [9];
    logic [5:0] op;
    logic [5:0] fn;
    int         sel;
    fn_tab = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
    op_tab = '{6'h00, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};

    reset = 1'b1;
    bus_if.op = 6'h00;
    bus_if.funct = 6'h00;
    bus_if.zero = 1'b0;
    bus_if.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_check(2, "por");

    g_tie = 1'b1;
    run(6'h09, 6'h00, 1'b0, 0, 0, 0, "addiu");
    g_tie = 1'b0;
    run(6'h0D, 6'h00, 1'b0, 0, 0, 0, "ori");
    run(6'h23, 6'h00, 1'b0, 0, 3, 0, "lw_wait3");
    run(6'h04, 6'h00, 1'b1, 0, 0, 0, "beq_taken");
    run(6'h04, 6'h00, 1'b0, 0, 0, 0, "beq_not_taken");
    run(6'h3F, 6'h00, 1'b0, 0, 0, 20, "ill_op3f");
    push_fetch_waits(2);
    play("fetch_wait");
    reset_check(1, "fetch_abort");
    run(6'h03, 6'h00, 1'b0, 1, 0, 3, "jal");
    run(6'h02, 6'h00, 1'b0, 0, 0, 0, "j");
    run(6'h2B, 6'h00, 1'b0, 2, 1, 0, "sw_waits");
    run(6'h0F, 6'h00, 1'b0, 1, 0, 0, "lui");
    for (int i = 0; i < 5; i++) run(6'h00, fn_tab[i], 1'b0, 0, 0, 0, "rtype");
    run(6'h00, 6'h3F, 1'b0, 0, 0, 3, "ill_funct");

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(9, 0);
      op  = (sel == 9) ? 6'($urandom_range(63, 0)) : op_tab[sel];
      sel = $urandom_range(5, 0);
      fn  = (sel == 5) ? 6'($urandom_range(63, 0)) : fn_tab[sel];
      run(op, fn, 1'($urandom_range(1, 0)), $urandom_range(3, 0),
          $urandom_range(3, 0), 3, "random");
      if ($urandom_range(7, 0) == 0) begin
        push_fetch_waits($urandom_range(3, 1));
        play("random_fetch_wait");
        reset_check(1, "random_fetch_abort");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
